// File: rtl/ide_pkg.sv
// Shared constants for the IDE PIO target: task-file addresses,
// opcodes, status/error bit positions and the controller state set.
package ide_pkg;

  localparam logic [1:0] CS_CMD = 2'b10;
  localparam logic [1:0] CS_CTL = 2'b01;

  localparam logic [2:0] RA_DATA   = 3'd0;
  localparam logic [2:0] RA_ERR    = 3'd1;
  localparam logic [2:0] RA_CNT    = 3'd2;
  localparam logic [2:0] RA_LBA0   = 3'd3;
  localparam logic [2:0] RA_LBA1   = 3'd4;
  localparam logic [2:0] RA_LBA2   = 3'd5;
  localparam logic [2:0] RA_DEV    = 3'd6;
  localparam logic [2:0] RA_CMD    = 3'd7;
  localparam logic [2:0] RA_DEVCTL = 3'd6;

  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_WRITE = 8'h30;

  localparam int ST_BSY  = 7;
  localparam int ST_DRDY = 6;
  localparam int ST_DSC  = 4;
  localparam int ST_DRQ  = 3;
  localparam int ST_ERR  = 0;
  localparam int ER_ABRT = 2;
  localparam int DC_SRST = 2;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRQ_RD,
    DRQ_WR,
    FLUSH,
    SRST
  } state_t;

endpackage

// File: rtl/ide_pio_target_if.sv
// Block-store port of the IDE PIO target: one word per
// req/ack handshake, addressed by drive, LBA and word index.
interface ide_pio_target_if #(
  parameter int DATA_W = 16,
  parameter int LBA_W  = 28,
  parameter int WORD_W = 8
);
  logic              blk_req;
  logic              blk_we;
  logic              blk_drive;
  logic [LBA_W-1:0]  blk_lba;
  logic [WORD_W-1:0] blk_word;
  logic [DATA_W-1:0] blk_wdata;
  logic [DATA_W-1:0] blk_rdata;
  logic              blk_ack;

  modport master (
    output blk_req, blk_we, blk_drive,
    output blk_lba, blk_word, blk_wdata,
    input  blk_rdata, blk_ack
  );

  modport slave (
    input  blk_req, blk_we, blk_drive,
    input  blk_lba, blk_word, blk_wdata,
    output blk_rdata, blk_ack
  );
endinterface

// File: rtl/ide_sector_buf.sv
// One-sector staging RAM: single port, registered read,
// read data follows the address one clock later.
module ide_sector_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ide_pio_target.sv
// IDE/ATA PIO device emulation: task file, strobe-edge decode,
// sector buffer and a req/ack block-store master.
module ide_pio_target
  import ide_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int SECTOR_WORDS = 256,
  parameter int LBA_W        = 28,
  parameter int NUM_DRIVES   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ide_data_in,
  output logic [DATA_W-1:0] ide_data_out,
  input  logic              ide_dior,
  input  logic              ide_diow,
  input  logic [1:0]        ide_cs,
  input  logic [2:0]        ide_da,
  ide_pio_target_if.master  blk
);

  localparam int WW = $clog2(SECTOR_WORDS);
  localparam logic [WW-1:0] LAST = WW'(SECTOR_WORDS - 1);

  state_t state, state_nx;

  logic rd_s, rd_p, wr_s, wr_p;
  logic [1:0] cs_l;
  logic [2:0] da_l;
  logic [DATA_W-1:0] wd_l;
  logic [7:0] cnt;
  logic [27:0] lba;
  logic [3:0] dev_hi;
  logic err, abrt;
  logic [WW-1:0] ptr;
  logic req, prime;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] buf_rdata, buf_wdata, rd_mux;
  logic buf_we;
  logic [7:0] status, stat_rd;

  logic rd_ev, wr_ev, cmd_blk, ctl_blk, drv_ok, bsy, drq;
  logic tf_wr, cmd_wr, cmd_ok, dc_wr, rd_adv, wr_adv;
  logic ack_hit, last, more, xfer, sec_done;

  // A strobe only counts if the other one was idle, so an
  // overlapping dior/diow pair is dropped entirely.
  assign rd_ev = rd_s & ~rd_p & wr_p;
  assign wr_ev = wr_s & ~wr_p & rd_p;

  assign cmd_blk = cs_l == CS_CMD;
  assign ctl_blk = cs_l == CS_CTL;
  assign drv_ok  = (NUM_DRIVES > 1) || !dev_hi[0];
  assign bsy     = state inside {FILL, FLUSH, SRST};
  assign drq     = state inside {DRQ_RD, DRQ_WR};

  assign tf_wr  = wr_ev && cmd_blk && da_l != RA_DATA
                  && !bsy && !drq;
  assign cmd_wr = tf_wr && da_l == RA_CMD && drv_ok;
  assign cmd_ok = wd_l[7:0] == CMD_READ
                  || wd_l[7:0] == CMD_WRITE;
  assign dc_wr  = wr_ev && ctl_blk && da_l == RA_DEVCTL;
  assign rd_adv = rd_ev && cmd_blk && da_l == RA_DATA
                  && state == DRQ_RD;
  assign wr_adv = wr_ev && cmd_blk && da_l == RA_DATA
                  && state == DRQ_WR;

  assign ack_hit  = req && blk.blk_ack;
  assign last     = ptr == LAST;
  assign more     = cnt != 8'd1;
  assign xfer     = state == FILL || state == FLUSH;
  assign sec_done = (rd_adv && last)
                    || (state == FLUSH && ack_hit && last);

  always_comb begin
    status = '0;
    if (state == SRST) begin
      status[ST_BSY] = 1'b1;
    end else begin
      status[ST_BSY]  = bsy;
      status[ST_DRDY] = 1'b1;
      status[ST_DSC]  = 1'b1;
      status[ST_DRQ]  = drq;
      status[ST_ERR]  = err;
    end
  end

  assign stat_rd = drv_ok ? status : 8'h00;

  always_comb begin
    rd_mux = '0;
    if (cmd_blk) begin
      unique case (da_l)
        RA_DATA: rd_mux = (state == DRQ_RD) ? buf_rdata : '0;
        RA_ERR:  rd_mux = DATA_W'({5'b0, abrt, 2'b0});
        RA_CNT:  rd_mux = DATA_W'(cnt);
        RA_LBA0: rd_mux = DATA_W'(lba[7:0]);
        RA_LBA1: rd_mux = DATA_W'(lba[15:8]);
        RA_LBA2: rd_mux = DATA_W'(lba[23:16]);
        RA_DEV:  rd_mux = DATA_W'({dev_hi, lba[27:24]});
        default: rd_mux = DATA_W'(stat_rd);
      endcase
    end else if (ctl_blk && da_l == RA_DEVCTL) begin
      rd_mux = DATA_W'(stat_rd);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_wr && wd_l[7:0] == CMD_READ) state_nx = FILL;
        else if (cmd_wr && wd_l[7:0] == CMD_WRITE) state_nx = DRQ_WR;
      end
      FILL:   if (ack_hit && last) state_nx = DRQ_RD;
      DRQ_RD: if (rd_adv && last) state_nx = more ? FILL : IDLE;
      DRQ_WR: if (wr_adv && last) state_nx = FLUSH;
      FLUSH:  if (ack_hit && last) state_nx = more ? DRQ_WR : IDLE;
      SRST:   if (dc_wr && !wd_l[DC_SRST]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (dc_wr && wd_l[DC_SRST]) state_nx = SRST;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end

  assign buf_we    = (state == FILL && ack_hit) || wr_adv;
  assign buf_wdata = (state == FILL) ? blk.blk_rdata : wd_l;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_s <= 1'b1;
      rd_p <= 1'b1;
      wr_s <= 1'b1;
      wr_p <= 1'b1;
      cs_l <= '0;
      da_l <= '0;
      wd_l <= '0;
      ide_data_out <= '0;
      cnt <= '0;
      lba <= '0;
      dev_hi <= '0;
      err <= 1'b0;
      abrt <= 1'b0;
      ptr <= '0;
      req <= 1'b0;
      prime <= 1'b0;
      wdata <= '0;
    end else begin
      rd_s <= ide_dior;
      rd_p <= rd_s;
      wr_s <= ide_diow;
      wr_p <= wr_s;
      if (!ide_dior || !ide_diow) begin
        cs_l <= ide_cs;
        da_l <= ide_da;
      end
      if (!ide_diow) wd_l <= ide_data_in;
      ide_data_out <= rd_s ? '0 : rd_mux;

      if (state_nx == SRST) begin
        req <= 1'b0;
        prime <= 1'b0;
        ptr <= '0;
      end else if (state == SRST) begin
        cnt <= '0;
        lba <= '0;
        dev_hi <= '0;
        err <= 1'b0;
        abrt <= 1'b0;
      end else begin
        if (tf_wr) begin
          unique case (da_l)
            RA_CNT:  cnt <= wd_l[7:0];
            RA_LBA0: lba[7:0] <= wd_l[7:0];
            RA_LBA1: lba[15:8] <= wd_l[7:0];
            RA_LBA2: lba[23:16] <= wd_l[7:0];
            RA_DEV: begin
              dev_hi <= wd_l[7:4];
              lba[27:24] <= wd_l[3:0];
            end
            default: ;
          endcase
        end
        if (cmd_wr) begin
          err <= !cmd_ok;
          abrt <= !cmd_ok;
          if (cmd_ok) ptr <= '0;
        end
        // prime spaces requests one clock apart and lets the
        // buffer read settle before a flush word is presented
        if (xfer) begin
          if (req) begin
            if (blk.blk_ack) begin
              req <= 1'b0;
              ptr <= ptr + WW'(1);
            end
          end else if (!prime) begin
            prime <= 1'b1;
          end else begin
            req <= 1'b1;
            prime <= 1'b0;
            if (state == FLUSH) wdata <= buf_rdata;
          end
        end
        if (rd_adv || wr_adv) ptr <= ptr + WW'(1);
        if (sec_done) begin
          cnt <= cnt - 8'd1;
          if (more) lba[LBA_W-1:0] <= lba[LBA_W-1:0] + LBA_W'(1);
        end
      end
    end
  end

  ide_sector_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SECTOR_WORDS)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (ptr),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  assign blk.blk_req   = req;
  assign blk.blk_we    = state == FLUSH;
  assign blk.blk_drive = dev_hi[0];
  assign blk.blk_lba   = lba[LBA_W-1:0];
  assign blk.blk_word  = ptr;
  assign blk.blk_wdata = wdata;

endmodule

// File: tb/tb_ide_pio_target.sv
// Directed bench for ide_pio_target: host PIO cycles plus a
// one-clock-ack block store that logs every completed handshake.
module tb_ide_pio_target;
  import ide_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] ide_data_in;
  logic [15:0] ide_data_out;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  ide_pio_target_if #(.DATA_W(16), .LBA_W(28), .WORD_W(8)) bif ();

  ide_pio_target #(
    .DATA_W(16), .SECTOR_WORDS(256), .LBA_W(28), .NUM_DRIVES(1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ide_data_in  (ide_data_in),
    .ide_data_out (ide_data_out),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da),
    .blk          (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [27:0] lg_lba[$];
  logic [7:0]  lg_word[$];
  logic        lg_we[$];
  logic [15:0] lg_wdata[$];

  // Store: ack one clock after req is seen; data word i = i.
  initial begin
    bif.blk_ack = 1'b0;
    bif.blk_rdata = '0;
    forever begin
      @(negedge clk);
      if (bif.blk_req && bif.blk_ack) begin
        lg_lba.push_back(bif.blk_lba);
        lg_word.push_back(bif.blk_word);
        lg_we.push_back(bif.blk_we);
        lg_wdata.push_back(bif.blk_wdata);
      end
      @(posedge clk);
      #1;
      if (bif.blk_ack) begin
        bif.blk_ack = 1'b0;
      end else if (bif.blk_req) begin
        bif.blk_ack = 1'b1;
        bif.blk_rdata = 16'(bif.blk_word);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    lg_lba.delete();
    lg_word.delete();
    lg_we.delete();
    lg_wdata.delete();
  endtask

  task automatic ide_wr(input logic [1:0] c, input logic [2:0] a,
                        input logic [15:0] d);
    ide_cs = c;
    ide_da = a;
    ide_data_in = d;
    ide_diow = 1'b0;
    repeat (3) @(posedge clk);
    #1 ide_diow = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ide_rd(input logic [1:0] c, input logic [2:0] a,
                        output logic [15:0] d);
    ide_cs = c;
    ide_da = a;
    ide_dior = 1'b0;
    repeat (3) @(posedge clk);
    #1 d = ide_data_out;
    ide_dior = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_status(input logic [7:0] exp, input string tag);
    logic [15:0] d;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      ide_rd(CS_CMD, RA_CMD, d);
      if (d == 16'(exp)) break;
    end
    check(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    logic [15:0] d;
    int errs;
    int n;

    reset_n = 1'b0;
    ide_data_in = '0;
    ide_dior = 1'b1;
    ide_diow = 1'b1;
    ide_cs = 2'b11;
    ide_da = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(ide_data_out), 0);
    check("rst_blk_req", 32'(bif.blk_req), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    ide_rd(CS_CMD, RA_CMD, d);
    check("rst_status", 32'(d), 32'h50);
    ide_rd(CS_CTL, RA_DEVCTL, d);
    check("rst_altstatus", 32'(d), 32'h50);
    ide_rd(CS_CMD, RA_DATA, d);
    check("idle_data_rd", 32'(d), 0);

    // overlapping strobes are dropped
    ide_cs = CS_CMD;
    ide_da = RA_LBA0;
    ide_data_in = 16'h0077;
    ide_dior = 1'b0;
    ide_diow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ide_dior = 1'b1;
    ide_diow = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ide_rd(CS_CMD, RA_LBA0, d);
    check("both_strobes", 32'(d), 0);

    // absent drive 1
    ide_wr(CS_CMD, RA_DEV, 16'h0010);
    ide_rd(CS_CMD, RA_CMD, d);
    check("dev1_status", 32'(d), 0);
    ide_rd(CS_CTL, RA_DEVCTL, d);
    check("dev1_alt", 32'(d), 0);
    ide_wr(CS_CMD, RA_CNT, 16'h0001);
    ide_wr(CS_CMD, RA_CMD, 16'h0020);
    repeat (6) @(posedge clk);
    #1;
    check("dev1_no_req", 32'(bif.blk_req), 0);
    ide_wr(CS_CMD, RA_DEV, 16'h00E0);
    ide_rd(CS_CMD, RA_CMD, d);
    check("dev1_cmd_ign", 32'(d), 32'h50);

    // one-sector read at LBA 0x10
    clear_log();
    ide_wr(CS_CMD, RA_CNT, 16'h0001);
    ide_wr(CS_CMD, RA_LBA0, 16'h0010);
    ide_wr(CS_CMD, RA_LBA1, 16'h0000);
    ide_wr(CS_CMD, RA_LBA2, 16'h0000);
    ide_wr(CS_CMD, RA_DEV, 16'h00E0);
    ide_wr(CS_CMD, RA_CMD, 16'h0020);
    ide_rd(CS_CMD, RA_CMD, d);
    check("rd_bsy", 32'(d), 32'hD0);
    wait_status(8'h58, "rd_drq");
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      ide_rd(CS_CMD, RA_DATA, d);
      if (d !== 16'(i)) errs++;
    end
    check("rd_data_errs", 32'(errs), 0);
    ide_rd(CS_CMD, RA_CMD, d);
    check("rd_done_status", 32'(d), 32'h50);
    check("rd_fetch_count", 32'(lg_word.size()), 256);
    errs = 0;
    foreach (lg_word[j]) begin
      if (lg_lba[j] !== 28'h10 || lg_word[j] !== 8'(j)
          || lg_we[j] !== 1'b0) errs++;
    end
    check("rd_fetch_addr", 32'(errs), 0);

    // two-sector write across the LBA wrap
    clear_log();
    ide_wr(CS_CMD, RA_CNT, 16'h0002);
    ide_wr(CS_CMD, RA_LBA0, 16'h00FF);
    ide_wr(CS_CMD, RA_LBA1, 16'h00FF);
    ide_wr(CS_CMD, RA_LBA2, 16'h00FF);
    ide_wr(CS_CMD, RA_DEV, 16'h00EF);
    ide_wr(CS_CMD, RA_CMD, 16'h0030);
    for (int s = 0; s < 2; s++) begin
      wait_status(8'h58, "wr_drq");
      if (s == 0) ide_wr(CS_CMD, RA_CNT, 16'h0055);
      for (int i = 0; i < 256; i++)
        ide_wr(CS_CMD, RA_DATA, 16'hC000 | 16'(s * 256 + i));
    end
    wait_status(8'h50, "wr_done");
    check("wr_store_count", 32'(lg_word.size()), 512);
    errs = 0;
    foreach (lg_word[j]) begin
      if (lg_lba[j] !== ((j < 256) ? 28'h0FFFFFFF : 28'h0)
          || lg_word[j] !== 8'(j) || lg_we[j] !== 1'b1
          || lg_wdata[j] !== (16'hC000 | 16'(j))) errs++;
    end
    check("wr_store_data", 32'(errs), 0);
    ide_rd(CS_CMD, RA_CNT, d);
    check("wr_cnt_end", 32'(d), 0);
    ide_rd(CS_CMD, RA_LBA0, d);
    check("wr_lba0_wrap", 32'(d), 0);
    ide_rd(CS_CMD, RA_DEV, d);
    check("wr_dev_wrap", 32'(d), 32'hE0);

    // unknown opcode, then a valid command clears the error
    ide_wr(CS_CMD, RA_CMD, 16'h0091);
    ide_rd(CS_CMD, RA_CMD, d);
    check("abrt_status", 32'(d), 32'h51);
    ide_rd(CS_CMD, RA_ERR, d);
    check("abrt_error", 32'(d), 32'h04);
    clear_log();
    ide_wr(CS_CMD, RA_CNT, 16'h0001);
    ide_wr(CS_CMD, RA_LBA0, 16'h0033);
    ide_wr(CS_CMD, RA_CMD, 16'h0020);
    ide_rd(CS_CMD, RA_CMD, d);
    check("abrt_cleared", 32'(d), 32'hD0);
    ide_rd(CS_CMD, RA_ERR, d);
    check("abrt_err_clr", 32'(d), 0);

    // soft reset in the middle of the fill
    for (int c = 0; c < 5000 && lg_word.size() < 100; c++)
      @(posedge clk);
    #1;
    check("fill_reach_100", 32'(lg_word.size() >= 100), 1);
    ide_wr(CS_CTL, RA_DEVCTL, 16'h0004);
    check("srst_req_low", 32'(bif.blk_req), 0);
    ide_rd(CS_CTL, RA_DEVCTL, d);
    check("srst_status", 32'(d), 32'h80);
    n = lg_word.size();
    repeat (50) @(posedge clk);
    #1;
    check("srst_no_ack", 32'(lg_word.size()), 32'(n));
    ide_wr(CS_CTL, RA_DEVCTL, 16'h0000);
    ide_rd(CS_CMD, RA_CMD, d);
    check("srst_release", 32'(d), 32'h50);
    ide_rd(CS_CMD, RA_LBA0, d);
    check("srst_tf_clr", 32'(d), 0);

    // hard reset during the write data phase
    clear_log();
    ide_wr(CS_CMD, RA_CNT, 16'h0001);
    ide_wr(CS_CMD, RA_LBA0, 16'h0005);
    ide_wr(CS_CMD, RA_CMD, 16'h0030);
    wait_status(8'h58, "wr2_drq");
    for (int i = 0; i < 10; i++)
      ide_wr(CS_CMD, RA_DATA, 16'h1000 + 16'(i));
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hrst_outs", {bif.blk_req, bif.blk_we, bif.blk_drive,
                        3'b0, bif.blk_word, ide_data_out}, 0);
    check("hrst_lba", 32'(bif.blk_lba), 0);
    check("hrst_wdata", 32'(bif.blk_wdata), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ide_rd(CS_CMD, RA_CMD, d);
    check("hrst_status", 32'(d), 32'h50);
    repeat (100) @(posedge clk);
    #1;
    check("hrst_no_flush", 32'(lg_word.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
